// File: rtl/ps2_led_ctrl.sv
// ps2_led_ctrl: PS/2 host sequencer that sends 0xED + LED byte whenever the requested LED state changes
module ps2_led_ctrl #(
    parameter int unsigned INHIBIT_CYC = 4800,
    parameter int unsigned TIMEOUT_CYC = 960000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [2:0] leds_in,
    input  logic       force_req,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int unsigned TMAX = INHIBIT_CYC > TIMEOUT_CYC ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int TW = $clog2(TMAX + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [2:0] IDLE = 3'd0, INHIBIT = 3'd1, TX = 3'd2, ACK = 3'd3,
                           RESP = 3'd4, RETRY = 3'd5, DONE = 3'd6;

    logic [2:0]    state;
    logic [3:0]    clk_hist, data_hist;
    logic          clk_f, data_f, fall;
    logic [TW-1:0] tmr;
    logic [RW-1:0] retry, retry_n;
    logic [3:0]    bcnt;
    logic [9:0]    rx;
    logic [2:0]    tx_leds, last_sent;
    logic          sel, pending, dbit, timeout, rx_ok;
    logic [7:0]    cur;
    logic [9:0]    txf;
    logic [10:0]   rxf;

    always_comb begin
        fall        = clk_f && clk_hist == 4'b0000;
        cur         = sel ? {5'b0, tx_leds} : 8'hED;
        txf         = {1'b1, ~^cur, cur};
        rxf         = {data_f, rx};
        rx_ok       = !rxf[0] && rxf[10] && (^rxf[9:1]) && rxf[8:1] == 8'hFA;
        timeout     = tmr == TW'(TIMEOUT_CYC - 1);
        retry_n     = retry + 1'b1;
        busy        = state != IDLE;
        done        = state == DONE;
        ps2_clk_oe  = state == INHIBIT;
        ps2_data_oe = state == TX && dbit;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            clk_hist  <= 4'hF;
            data_hist <= 4'hF;
            clk_f     <= 1'b1;
            data_f    <= 1'b1;
            tmr       <= '0;
            retry     <= '0;
            bcnt      <= '0;
            rx        <= '0;
            tx_leds   <= '0;
            last_sent <= '0;
            sel       <= 1'b0;
            pending   <= 1'b1;
            dbit      <= 1'b0;
            error     <= 1'b0;
        end else begin
            clk_hist  <= {clk_hist[2:0], ps2_clk_in};
            data_hist <= {data_hist[2:0], ps2_data_in};
            clk_f     <= clk_hist == 4'b0000 ? 1'b0 : clk_hist == 4'b1111 ? 1'b1 : clk_f;
            data_f    <= data_hist == 4'b0000 ? 1'b0 : data_hist == 4'b1111 ? 1'b1 : data_f;
            // while busy, compare against the in-flight value so only a real change queues a follow-up
            if (state == IDLE && pending)
                pending <= 1'b0;
            else if (force_req || leds_in != (state == IDLE ? last_sent : tx_leds))
                pending <= 1'b1;
            if (state == TX || state == ACK || state == RESP)
                tmr <= fall ? '0 : tmr + 1'b1;
            case (state)
                IDLE: if (pending) begin
                    state   <= INHIBIT;
                    tx_leds <= leds_in;
                    sel     <= 1'b0;
                    retry   <= '0;
                    tmr     <= '0;
                end
                INHIBIT: if (tmr == TW'(INHIBIT_CYC - 1)) begin
                    state <= TX;
                    tmr   <= '0;
                    bcnt  <= '0;
                    dbit  <= 1'b1;
                end else tmr <= tmr + 1'b1;
                TX: if (fall) begin
                    dbit  <= ~txf[bcnt];
                    bcnt  <= bcnt + 1'b1;
                    state <= bcnt == 4'd9 ? ACK : TX;
                end else if (timeout) state <= RETRY;
                ACK: if (fall) begin
                    bcnt  <= '0;
                    state <= data_f ? RETRY : RESP;
                end else if (timeout) state <= RETRY;
                RESP: if (fall) begin
                    rx   <= {data_f, rx[9:1]};
                    bcnt <= bcnt + 1'b1;
                    if (bcnt == 4'd10) begin
                        if (!rx_ok) state <= RETRY;
                        else if (!sel) begin
                            state <= INHIBIT;
                            sel   <= 1'b1;
                            retry <= '0;
                        end else begin
                            state     <= DONE;
                            last_sent <= tx_leds;
                            error     <= 1'b0;
                        end
                    end
                end else if (timeout) state <= RETRY;
                RETRY: begin
                    tmr <= '0;
                    if (retry_n == RW'(MAX_RETRY)) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        retry <= retry_n;
                        state <= INHIBIT;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
